cpcs_mux_arbiter: RTL

Round-robin arbiter and sequencer for the CorePCS 8B10B encode-path 4:1 data mux. Four upstream requesters compete for the shared encoder input. The block grants one requester at a time for a whole frame and drives the mux select lines, so that requester's data reaches the encoder. It sits directly in front of the mux in the transmit datapath and runs entirely in the encoder clock domain.

---
 rtl/cpcs_mux_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cpcs_mux_arbiter.sv
// cpcs_mux_arbiter: round-robin frame arbiter driving the 4:1 encoder-input mux select.
// Latency: REQ/EOF sampled at an edge update GNT/SEL/ACTIVE on that same edge (registered outputs).
// Backpressure: none; a grant is held for a whole frame until EOF, REQ drop or (optional) timeout.
//
// Ports:
//   CLK      encoder clock, all logic on the rising edge
//   RESET_N  synchronous active-low reset
//   REQ[3:0] per-requester request
//   EOF[3:0] per-requester end-of-frame; only the owner's bit is looked at
//   SEL[1:0] registered mux select = binary index of the owner (holds when idle)
//   GNT[3:0] registered one-hot grant, zero when idle
//   ACTIVE   registered, high while a grant is held
//   PREEMPT  one-cycle pulse aligned with the new grant after a timeout release
//
// Optional feature macro: CPCS_ARB_TIMEOUT_EN (burst timeout with MAX_BURST limit).

module cpcs_mux_arbiter #(
  parameter int MAX_BURST = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] REQ,
  input  logic [3:0] EOF,
  output logic [1:0] SEL,
  output logic [3:0] GNT,
  output logic       ACTIVE,
  output logic       PREEMPT
);

  if (MAX_BURST < 2 || MAX_BURST > 256) begin : g_bad_max_burst
    $error("cpcs_mux_arbiter: MAX_BURST must be in 2..256");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] sel_nxt;
  logic [3:0] gnt_nxt;
  logic       active_nxt;

  logic       timeout;
  logic       rel;
  logic [1:0] arb_base;
  logic [2:0] win;     // {found, index}

  // First set bit of req in the order base, base+1, base+2, base+3 (mod 4).
  // Walk from the far end so the nearest hit overwrites the result last.
  function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] base);
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (req[idx]) pick = {1'b1, idx};
    end
  endfunction

  // The owner releases on its EOF, on dropping its request, or on timeout.
  assign rel      = EOF[SEL] | ~REQ[SEL] | timeout;
  // On release the search starts just past the old owner, so it ends up last.
  assign arb_base = (state == BUSY) ? SEL + 2'd1 : ptr;
  assign win      = pick(REQ, arb_base);

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    sel_nxt    = SEL;
    gnt_nxt    = GNT;
    active_nxt = ACTIVE;
    case (state)
      IDLE: begin
        if (win[2]) begin
          sel_nxt    = win[1:0];
          gnt_nxt    = 4'b0001 << win[1:0];
          active_nxt = 1'b1;
          state_nxt  = BUSY;
        end
      end
      BUSY: begin
        if (rel) begin
          ptr_nxt = SEL + 2'd1;
          if (win[2]) begin
            sel_nxt = win[1:0];
            gnt_nxt = 4'b0001 << win[1:0];
          end else begin
            // SEL keeps its value so the mux output does not move while idle.
            gnt_nxt    = 4'b0000;
            active_nxt = 1'b0;
            state_nxt  = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state  <= IDLE;
      ptr    <= 2'd0;
      SEL    <= 2'd0;
      GNT    <= 4'b0000;
      ACTIVE <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      SEL    <= sel_nxt;
      GNT    <= gnt_nxt;
      ACTIVE <= active_nxt;
    end
  end

`ifdef CPCS_ARB_TIMEOUT_EN
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  logic [7:0] beat_cnt, beat_nxt;
  logic       new_grant;

  // Forced release only when the owner still wants the bus, has not ended the
  // frame itself, and somebody else is waiting; otherwise it is a plain release.
  assign timeout = (state == BUSY) && (beat_cnt == BURST_LAST) &&
                   !EOF[SEL] && REQ[SEL] && |(REQ & ~GNT);

  assign new_grant = win[2] && ((state == IDLE) || rel);

  // Counter saturates at the limit so a late competitor preempts immediately.
  always_comb begin
    beat_nxt = beat_cnt;
    if (new_grant)
      beat_nxt = 8'd0;
    else if (state == BUSY && beat_cnt != BURST_LAST)
      beat_nxt = beat_cnt + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      beat_cnt <= 8'd0;
      PREEMPT  <= 1'b0;
    end else begin
      beat_cnt <= beat_nxt;
      PREEMPT  <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign PREEMPT = 1'b0;
`endif

endmodule
